// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset controller: opcodes,
// ALU operation codes, datapath mux selects and the controller state set.
package riscv_pkg;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b100
   } alu_op_t;

   typedef enum logic [1:0] {
      RES_ALUOUT    = 2'b00,
      RES_DATA      = 2'b01,
      RES_ALURESULT = 2'b10,
      RES_IMM       = 2'b11
   } result_src_t;

   typedef enum logic [1:0] {
      SRCA_PC    = 2'b00,
      SRCA_OLDPC = 2'b01,
      SRCA_REGA  = 2'b10
   } alu_src_a_t;

   typedef enum logic [1:0] {
      SRCB_REGB = 2'b00,
      SRCB_IMM  = 2'b01,
      SRCB_FOUR = 2'b10
   } alu_src_b_t;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_t;

   // Instruction classes that matter to the ALU operation decoder
   typedef enum logic [1:0] {
      CLS_R      = 2'b00,
      CLS_I      = 2'b01,
      CLS_BRANCH = 2'b10,
      CLS_OTHER  = 2'b11
   } op_class_t;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      JALR     = 4'd11,
      LUI      = 4'd12
   } state_t;

   function automatic op_class_t op_class(input logic [6:0] op);
      case (op)
         OP_R:    return CLS_R;
         OP_I:    return CLS_I;
         OP_BR:   return CLS_BRANCH;
         default: return CLS_OTHER;
      endcase
   endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU operation decoder: instruction class + funct fields
// give the ALUOp code and whether the funct combination is supported.
module alu_op_decoder
   import riscv_pkg::*;
(
   input  op_class_t  op_class_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   output logic [2:0] alu_op_o,
   output logic       legal_o
);

   // Classes other than R/I/branch always add; opcode legality is the FSM's job
   always_comb begin
      alu_op_o = ALU_ADD;
      legal_o  = 1'b1;
      case (op_class_i)
         CLS_R: begin
            case (funct3_i)
               3'b000:  alu_op_o = funct7b5_i ? ALU_SUB : ALU_ADD;
               3'b111: begin alu_op_o = ALU_AND; legal_o = !funct7b5_i; end
               3'b110: begin alu_op_o = ALU_OR;  legal_o = !funct7b5_i; end
               3'b010: begin alu_op_o = ALU_SLT; legal_o = !funct7b5_i; end
               default: legal_o = 1'b0;
            endcase
         end
         CLS_I: begin
            case (funct3_i)
               3'b000:  alu_op_o = ALU_ADD;
               3'b111:  alu_op_o = ALU_AND;
               3'b110:  alu_op_o = ALU_OR;
               3'b010:  alu_op_o = ALU_SLT;
               default: legal_o = 1'b0;
            endcase
         end
         CLS_BRANCH: begin
            case (funct3_i)
               3'b000, 3'b001: alu_op_o = ALU_SUB;
               3'b100, 3'b101: alu_op_o = ALU_SLT;
               default:        legal_o  = 1'b0;
            endcase
         end
         default: begin
            alu_op_o = ALU_ADD;
            legal_o  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32I-subset control FSM driving the shared PC/IR/memory/
// register-file datapath and the 3-bit ALUOp / Zero ALU interface.
module multi_cycle_controller
   import riscv_pkg::*;
#(
   parameter state_t RESET_STATE = FETCH
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ImmSrc,
   output logic [2:0] ALUOp,
   output logic       Illegal
);

   state_t     state_q;
   state_t     state_eff;
   logic [2:0] dec_alu_op;
   logic       dec_legal;
   logic       op_known;

   alu_op_decoder u_alu_op_decoder (
      .op_class_i (op_class(op)),
      .funct3_i   (funct3),
      .funct7b5_i (funct7b5),
      .alu_op_o   (dec_alu_op),
      .legal_o    (dec_legal)
   );

   // Opcodes the controller knows how to sequence
   always_comb begin
      case (op)
         OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI: op_known = 1'b1;
         default: op_known = 1'b0;
      endcase
   end

   // While reset is held the outputs present FETCH values with strobes masked
   assign state_eff = rst ? state_q : FETCH;

   // State register and next-state selection
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= RESET_STATE;
      end else begin
         case (state_q)
            FETCH:  state_q <= DECODE;
            DECODE: begin
               if (!dec_legal) begin
                  state_q <= FETCH;
               end else begin
                  case (op)
                     OP_R:         state_q <= EXECR;
                     OP_I:         state_q <= EXECI;
                     OP_LW, OP_SW: state_q <= MEMADR;
                     OP_BR:        state_q <= BRANCH;
                     OP_JAL:       state_q <= JAL;
                     OP_JALR:      state_q <= JALR;
                     OP_LUI:       state_q <= LUI;
                     default:      state_q <= FETCH;
                  endcase
               end
            end
            MEMADR:   state_q <= (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_q <= MEMWB;
            MEMWB:    state_q <= FETCH;
            MEMWRITE: state_q <= FETCH;
            EXECR:    state_q <= ALUWB;
            EXECI:    state_q <= ALUWB;
            ALUWB:    state_q <= FETCH;
            BRANCH:   state_q <= FETCH;
            JALR:     state_q <= JAL;
            JAL:      state_q <= ALUWB;
            LUI:      state_q <= FETCH;
            default:  state_q <= FETCH;
         endcase
      end
   end

   // Datapath control decode from the effective state and instruction fields
   always_comb begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_REGB;
      ImmSrc    = IMM_I;
      ALUOp     = ALU_ADD;
      Illegal   = 1'b0;
      case (state_eff)
         FETCH: begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
         end
         DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
            Illegal = !op_known || !dec_legal;
         end
         MEMADR: begin
            ALUSrcA = SRCA_REGA;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = (op == OP_SW) ? IMM_S : IMM_I;
         end
         MEMREAD: AdrSrc = 1'b1;
         MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         EXECR: begin
            ALUSrcA = SRCA_REGA;
            ALUOp   = dec_alu_op;
         end
         EXECI: begin
            ALUSrcA = SRCA_REGA;
            ALUSrcB = SRCB_IMM;
            ALUOp   = dec_alu_op;
         end
         ALUWB: RegWrite = 1'b1;
         BRANCH: begin
            ALUSrcA = SRCA_REGA;
            ALUOp   = dec_alu_op;
            // beq/bge take on Zero, bne/blt on !Zero
            PCWrite = Zero ^ (funct3[0] ^ funct3[2]);
         end
         JALR: begin
            ALUSrcA = SRCA_REGA;
            ALUSrcB = SRCB_IMM;
         end
         JAL: begin
            PCWrite = 1'b1;
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
         end
         LUI: begin
            ImmSrc    = IMM_U;
            ResultSrc = RES_IMM;
            RegWrite  = 1'b1;
         end
         default: ;
      endcase
      if (!rst) begin
         PCWrite  = 1'b0;
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         Illegal  = 1'b0;
      end
   end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: per-cycle expected control
// vectors are queued per instruction and popped as each cycle is sampled.
module tb_multi_cycle_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ImmSrc, ALUOp;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [17:0] sb[$];
   string       tag;

   multi_cycle_controller #(.RESET_STATE(riscv_pkg::FETCH)) dut (
      .clk       (clk),
      .rst       (rst),
      .op        (op),
      .funct3    (funct3),
      .funct7b5  (funct7b5),
      .Zero      (Zero),
      .PCWrite   (PCWrite),
      .AdrSrc    (AdrSrc),
      .MemWrite  (MemWrite),
      .IRWrite   (IRWrite),
      .RegWrite  (RegWrite),
      .ResultSrc (ResultSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ImmSrc    (ImmSrc),
      .ALUOp     (ALUOp),
      .Illegal   (Illegal)
   );

   always #5 clk = ~clk;

   // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,A,B,ImmSrc,ALUOp,Illegal}
   function automatic logic [17:0] ev(input logic pcw, input logic adr, input logic memw,
                                      input logic irw, input logic regw, input logic [1:0] res,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [2:0] imm, input logic [2:0] alu,
                                      input logic ill);
      return {pcw, adr, memw, irw, regw, res, a, b, imm, alu, ill};
   endfunction

   logic [17:0] FETCH_V, RST_V, DEC_B_V, DEC_J_V, ALUWB_V, JAL_V;

   task automatic step(input logic r, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z);
      logic [17:0] obs, exp;
      #1;
      rst = r; op = o; funct3 = f3; funct7b5 = f7; Zero = z;
      @(negedge clk);
      obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ImmSrc, ALUOp, Illegal};
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL %s: scoreboard empty, observed %b", tag, obs);
      end else begin
         exp = sb.pop_front();
         assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
         end
      end
      @(posedge clk);
   endtask

   task automatic run(input string t, input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, input logic z);
      int unsigned n;
      tag = t;
      n = sb.size();
      for (int unsigned i = 0; i < n; i++) step(1'b1, o, f3, f7, z);
   endtask

   initial begin
      FETCH_V = ev(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0);
      RST_V   = ev(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0);
      DEC_B_V = ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b010, 3'b000, 0);
      DEC_J_V = ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b011, 3'b000, 0);
      ALUWB_V = ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1);
      ALUWB_V = ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
      JAL_V   = ev(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0);

      rst = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0;
      @(posedge clk);

      // Reset held two cycles with a taken-branch pattern on the inputs
      tag = "reset";
      sb.push_back(RST_V); sb.push_back(RST_V);
      step(1'b0, 7'b1100011, 3'b000, 1'b0, 1'b1);
      step(1'b0, 7'b1100011, 3'b000, 1'b0, 1'b1);

      // add x3,x1,x2
      sb.push_back(FETCH_V); sb.push_back(DEC_B_V);
      sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0));
      sb.push_back(ALUWB_V);
      run("add", 7'b0110011, 3'b000, 1'b0, 1'b0);

      // sub
      sb.push_back(FETCH_V); sb.push_back(DEC_B_V);
      sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0));
      sb.push_back(ALUWB_V);
      run("sub", 7'b0110011, 3'b000, 1'b1, 1'b0);

      // ori with funct7b5 set (ignored for I-type)
      sb.push_back(FETCH_V); sb.push_back(DEC_B_V);
      sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b011, 0));
      sb.push_back(ALUWB_V);
      run("ori", 7'b0010011, 3'b110, 1'b1, 1'b0);

      // lw
      sb.push_back(FETCH_V); sb.push_back(DEC_B_V);
      sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
      sb.push_back(ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
      sb.push_back(ev(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0));
      run("lw", 7'b0000011, 3'b010, 1'b0, 1'b0);

      // sw
      sb.push_back(FETCH_V); sb.push_back(DEC_B_V);
      sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 0));
      sb.push_back(ev(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
      run("sw", 7'b0100011, 3'b010, 1'b0, 1'b0);

      // beq, Zero=1 -> taken
      sb.push_back(FETCH_V); sb.push_back(DEC_B_V);
      sb.push_back(ev(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0));
      run("beq", 7'b1100011, 3'b000, 1'b0, 1'b1);

      // bne, Zero=1 -> not taken
      sb.push_back(FETCH_V); sb.push_back(DEC_B_V);
      sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0));
      run("bne", 7'b1100011, 3'b001, 1'b0, 1'b1);

      // blt, Zero=0 -> taken
      sb.push_back(FETCH_V); sb.push_back(DEC_B_V);
      sb.push_back(ev(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b100, 0));
      run("blt", 7'b1100011, 3'b100, 1'b0, 1'b0);

      // bge, Zero=0 -> not taken
      sb.push_back(FETCH_V); sb.push_back(DEC_B_V);
      sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b100, 0));
      run("bge", 7'b1100011, 3'b101, 1'b0, 1'b0);

      // jal
      sb.push_back(FETCH_V); sb.push_back(DEC_J_V);
      sb.push_back(JAL_V); sb.push_back(ALUWB_V);
      run("jal", 7'b1101111, 3'b000, 1'b0, 1'b0);

      // jalr
      sb.push_back(FETCH_V); sb.push_back(DEC_B_V);
      sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
      sb.push_back(JAL_V); sb.push_back(ALUWB_V);
      run("jalr", 7'b1100111, 3'b000, 1'b0, 1'b0);

      // lui
      sb.push_back(FETCH_V); sb.push_back(DEC_B_V);
      sb.push_back(ev(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b100, 3'b000, 0));
      run("lui", 7'b0110111, 3'b000, 1'b0, 1'b0);

      // unknown opcode: Illegal in DECODE, then straight back to FETCH
      sb.push_back(FETCH_V);
      sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b010, 3'b000, 1));
      run("illegal_op", 7'b1111111, 3'b000, 1'b0, 1'b1);

      // R-type with unsupported funct3
      sb.push_back(FETCH_V);
      sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b010, 3'b000, 1));
      run("illegal_f3", 7'b0110011, 3'b001, 1'b0, 1'b0);

      // sw aborted by reset in its MEMWRITE cycle
      sb.push_back(FETCH_V); sb.push_back(DEC_B_V);
      sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 0));
      run("sw_abort", 7'b0100011, 3'b010, 1'b0, 1'b0);
      tag = "sw_abort_rst";
      sb.push_back(RST_V);
      step(1'b0, 7'b0100011, 3'b010, 1'b0, 1'b0);

      // FETCH follows reset release
      sb.push_back(FETCH_V); sb.push_back(DEC_B_V);
      sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b010, 0));
      sb.push_back(ALUWB_V);
      sb.push_back(FETCH_V);
      run("and_after_abort", 7'b0110011, 3'b111, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
- Multi-cycle RV32I-subset control FSM.
- Drives the shared datapath: PC, IR, memory, register file, muxes and the 3-bit ALUOp/Zero ALU interface.
- It is the producer end of that interface: it issues ALUOp (000 add, 001 sub, 010 and, 011 or, 100 slt) and consumes Zero for branch resolution.
- One instruction takes 3-5 cycles.

Parameters:
RESET_STATE, FETCH, state entered on reset (encoding from riscv_pkg)

Ports:
clk  in  1  system clock, all state changes on rising edge
rst  in  1  synchronous, active-low reset
op  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7b5  in  1  IR[30]
Zero  in  1  ALU zero flag (combinational, current cycle)
PCWrite  out  1  PC load enable
AdrSrc  out  1  memory address: 0 = PC, 1 = Result
MemWrite  out  1  data memory write
IRWrite  out  1  IR and OldPC load
RegWrite  out  1  register file write
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 Imm
ALUSrcA  out  2  00 PC, 01 OldPC, 10 RegA
ALUSrcB  out  2  00 RegB, 01 Imm, 10 constant 4
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
ALUOp  out  3  ALU operation, encoding above
Illegal  out  1  one-cycle pulse: unsupported op/funct

Behaviour:
- Reset: rst==0 at an edge -> state=FETCH. While rst==0, PCWrite, MemWrite, IRWrite, RegWrite and Illegal are forced 0. Other outputs show FETCH values.
- Outputs are combinational from state, op, funct3, funct7b5 and Zero. Unlisted outputs default to 0 / 000.
- FETCH: AdrSrc=0, IRWrite=1, A=00, B=10, ALUOp=000, ResultSrc=10, PCWrite=1 -> DECODE.
- DECODE: A=01, B=01, ALUOp=000, ImmSrc=J if jal else B (ALUOut <- branch/jump target). Next state by op:
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 0000011 / 0100011 -> MEMADR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - other -> Illegal=1, FETCH
- MEMADR: A=10, B=01, ALUOp=000, ImmSrc=I (lw) or S (sw); -> MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 -> FETCH.
- EXECR: A=10, B=00, ALUOp from decoder -> ALUWB.
- EXECI: A=10, B=01, ImmSrc=I, ALUOp from decoder -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BRANCH: A=10, B=00, ResultSrc=00.
  - beq: ALUOp=001, PCWrite=Zero.
  - bne: ALUOp=001, PCWrite=!Zero.
  - blt: ALUOp=100, PCWrite=!Zero.
  - bge: ALUOp=100, PCWrite=Zero.
  - -> FETCH.
- JALR: A=10, B=01, ImmSrc=I, ALUOp=000 (ALUOut <- rs1+imm) -> JAL.
- JAL: ResultSrc=00, PCWrite=1, A=01, B=10, ALUOp=000 (ALUOut <- OldPC+4) -> ALUWB.
- LUI: ImmSrc=U, ResultSrc=11, RegWrite=1 -> FETCH.
- Decoder rules:
  - R-type: 000 with f7b5=0 add, f7b5=1 sub; 111 and; 110 or; 010 slt.
  - I-type: 000 add, 111 and, 110 or, 010 slt; funct7b5 ignored.
  - Branch funct3: 000, 001, 100, 101.
  - Any other funct3/combination: DECODE pulses Illegal and returns to FETCH. No write enable asserts for that instruction.
- Cycle counts: lw 5; R/I/sw/jal 4; jalr 5; branch/lui 3.
- Reset mid-instruction aborts it: no write strobe is issued in the reset cycle, and FETCH follows release.
- Unreachable state encodings -> FETCH on the next edge.

Decomposition:
- riscv_pkg holds: opcode constants; ALUOp codes; ResultSrc/ALUSrcA/ALUSrcB/ImmSrc encodings; state enum.
- Sub-module alu_op_decoder (combinational): op class + funct3 + funct7b5 -> ALUOp and a legal flag.
- The FSM is instantiated in multi_cycle_controller.

Test Plan:
- Reset: rst=0 for 2 cycles, release -> state FETCH; IRWrite=1, PCWrite=1 in the first cycle; no strobes while rst=0.
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0) -> FETCH, DECODE, EXECR (ALUOp=000, A=10, B=00), ALUWB (RegWrite=1, ResultSrc=00). Repeat with f7b5=1 -> ALUOp=001.
- lw then sw -> lw: MEMADR (ImmSrc=000), MEMREAD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1). sw: MEMWRITE=1 only in its 4th cycle.
- beq with Zero=1 -> PCWrite=1 in BRANCH. bne with Zero=1 -> PCWrite=0. blt with Zero=0 -> ALUOp=100, PCWrite=1.
- jal, then jalr -> jal: JAL (PCWrite=1), ALUWB (RegWrite=1), 4 cycles. jalr: JALR (ImmSrc=000), JAL, ALUWB, 5 cycles.
- op=1111111, and R-type f3=001 -> Illegal=1 in DECODE, next FETCH; RegWrite, MemWrite and PCWrite stay 0. Also assert rst=0 during MEMWRITE -> MemWrite=0 that cycle.
